// File: rtl/dc_probe_capture.sv
// ---------------------------------------------------------------------------
// dc_probe_capture
//
// DC transfer-curve sweep engine. A run drives a series of source codes
// (start_code, start_code+step_inc, ... modulo 2^DW) into the input node of a
// circuit under test. For each code it waits a fixed settle time, averages
// 2^AVG_LOG2 far-end ADC samples and offers the average, tagged with the step
// index, on a valid/ready result port. After NSTEPS results it pulses done.
//
// Optional feature (macro DC_PROBE_SHORT_CHECK_EN): adds a short-circuit
// detector that flags when the averaged far-end sample lies within short_tol
// of the drive code.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, abort            run request (taken in IDLE only), run cancel
//   start_code, step_inc    first drive code and per-step increment
//   drive_code, drive_en    source code and source enable
//   adc_valid, adc_data     far-end sample strobe and value
//   res_valid, res_ready    result handshake
//   res_data, res_idx       averaged sample and step index
//   busy, done              run active, single-cycle completion pulse
//   short_tol, short_flag   (DC_PROBE_SHORT_CHECK_EN only) tolerance, flag
// ---------------------------------------------------------------------------
module dc_probe_capture #(
    parameter int DW         = 12,
    parameter int SETTLE_CYC = 16,
    parameter int AVG_LOG2   = 2,
    parameter int NSTEPS     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] start_code,
    input  logic [DW-1:0] step_inc,
    output logic [DW-1:0] drive_code,
    output logic          drive_en,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic [7:0]    res_idx,
    output logic          busy,
`ifdef DC_PROBE_SHORT_CHECK_EN
    input  logic [DW-1:0] short_tol,
    output logic          short_flag,
`endif
    output logic          done
);

    localparam int AW   = DW + AVG_LOG2;   // accumulator width, cannot overflow
    localparam int CW   = AVG_LOG2 + 1;    // sample counter width
    localparam int NAVG = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        EMIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   drive_code_reg;
    logic [DW-1:0]   step_reg;
    logic [7:0]      k_reg;
    logic [7:0]      settle_cnt_reg;
    logic [CW-1:0]   samp_cnt_reg;
    logic [AW-1:0]   acc_reg;
    logic            res_valid_reg;
    logic [DW-1:0]   res_data_reg;
    logic [7:0]      res_idx_reg;

    // FSM strobes
    logic start_go;
    logic sample_take;
    logic sample_last;
    logic xfer;
    logic step_adv;

    // Averaging datapath
    logic [AW-1:0] acc_sum;
    logic [DW-1:0] avg_new;

    assign acc_sum = acc_reg + AW'(adc_data);
    assign avg_new = DW'(acc_sum >> AVG_LOG2);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        start_go    = 1'b0;
        sample_take = 1'b0;
        sample_last = 1'b0;
        xfer        = 1'b0;
        step_adv    = 1'b0;
        if (abort) begin
            // Abort wins over start and over a pending result transfer.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        start_go   = 1'b1;
                        state_next = DRIVE;
                    end
                end
                DRIVE: begin
                    state_next = SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_reg == 8'(SETTLE_CYC - 1)) begin
                        state_next = SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (adc_valid) begin
                        sample_take = 1'b1;
                        if (samp_cnt_reg == CW'(NAVG - 1)) begin
                            sample_last = 1'b1;
                            state_next  = EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        xfer = 1'b1;
                        if (k_reg == 8'(NSTEPS - 1)) begin
                            state_next = DONE;
                        end else begin
                            step_adv   = 1'b1;
                            state_next = DRIVE;
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_code_reg <= '0;
            step_reg       <= '0;
            k_reg          <= '0;
            settle_cnt_reg <= '0;
            samp_cnt_reg   <= '0;
            acc_reg        <= '0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_idx_reg    <= '0;
        end else if (abort) begin
            // drive_code deliberately keeps its last value.
            k_reg          <= '0;
            settle_cnt_reg <= '0;
            samp_cnt_reg   <= '0;
            acc_reg        <= '0;
            res_valid_reg  <= 1'b0;
        end else begin
            if (start_go) begin
                drive_code_reg <= start_code;
                step_reg       <= step_inc;
                k_reg          <= '0;
                samp_cnt_reg   <= '0;
                acc_reg        <= '0;
            end

            if (state_reg == DRIVE) begin
                settle_cnt_reg <= '0;
            end else if (state_reg == SETTLE) begin
                settle_cnt_reg <= settle_cnt_reg + 8'd1;
            end

            if (sample_take) begin
                if (sample_last) begin
                    acc_reg       <= '0;
                    samp_cnt_reg  <= '0;
                    res_data_reg  <= avg_new;
                    res_idx_reg   <= k_reg;
                    res_valid_reg <= 1'b1;
                end else begin
                    acc_reg      <= acc_sum;
                    samp_cnt_reg <= samp_cnt_reg + 1'b1;
                end
            end

            if (xfer) begin
                res_valid_reg <= 1'b0;
            end

            // Running sum equals start_code + k*step_inc modulo 2^DW.
            if (step_adv) begin
                k_reg          <= k_reg + 8'd1;
                drive_code_reg <= drive_code_reg + step_reg;
            end
        end
    end

`ifdef DC_PROBE_SHORT_CHECK_EN
    // ---------------------------------------------------- short detector
    logic          short_flag_reg;
    logic [DW-1:0] short_diff;
    logic          short_hit;

    assign short_diff = (avg_new >= drive_code_reg) ? (avg_new - drive_code_reg)
                                                    : (drive_code_reg - avg_new);
    assign short_hit  = (short_diff <= short_tol);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_flag_reg <= 1'b0;
        end else if (abort || start_go) begin
            short_flag_reg <= 1'b0;
        end else if (sample_last) begin
            // Evaluated on the same edge the average is captured (EMIT entry).
            short_flag_reg <= short_hit;
        end
    end

    assign short_flag = short_flag_reg;
`endif

    // ------------------------------------------------------------ outputs
    assign drive_code = drive_code_reg;
    assign drive_en   = (state_reg == DRIVE)  || (state_reg == SETTLE) ||
                        (state_reg == SAMPLE) || (state_reg == EMIT);
    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_idx    = res_idx_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);

endmodule
